// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU/ImmSel/WBSel codes, FSM states.
// Latency: n/a (types, constants and pure combinational helper functions).
// Backpressure: n/a.
package riscv_pkg;

    // Controller states, encoded as they appear on the state output
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    // Major opcodes the controller understands
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_AND  = 4'b1010;

    // Immediate format selects
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Register write-back source selects
    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // Instruction class derived from the opcode
    typedef enum logic [3:0] {
        CLS_R,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } instr_cls_e;

    // Map a 7-bit opcode onto its instruction class
    function automatic instr_cls_e classify(input logic [6:0] opcode);
        instr_cls_e cls;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_IALU:   cls = CLS_IALU;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // An instruction is executable unless its opcode is unknown, it is a
    // branch with a reserved funct3, or an R-type with a reserved funct7
    function automatic logic is_legal(input instr_cls_e cls,
                                      input logic [2:0] funct3,
                                      input logic [6:0] funct7);
        logic ok;
        case (cls)
            CLS_ILLEGAL: ok = 1'b0;
            CLS_BRANCH:  ok = (funct3 != 3'b010) && (funct3 != 3'b011);
            CLS_R:       ok = (funct7 == 7'h00) || (funct7 == 7'h20);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// ALU operation decode from opcode/funct3/funct7.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_sel
);

    logic is_r;
    logic alt;
    logic unused_funct7_bits;

    assign is_r = (opcode == OPC_R);
    // Only funct7[5] distinguishes sub/sra from add/srl
    assign alt  = funct7[5];
    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    // Select the ALU operation; address-forming classes always add
    always_comb begin
        alu_sel = ALU_NONE;
        if (is_r || (opcode == OPC_IALU)) begin
            case (funct3)
                3'b000:  alu_sel = (is_r && alt) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
        end else if ((opcode == OPC_LOAD)   || (opcode == OPC_STORE) ||
                     (opcode == OPC_BRANCH) || (opcode == OPC_JAL)   ||
                     (opcode == OPC_JALR)   || (opcode == OPC_AUIPC)) begin
            alu_sel = ALU_ADD;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory, write-back.
// Latency: 4 cycles per instruction (5 for loads/stores) plus imem/dmem waits.
// Backpressure: stalls in FETCH until instr_valid and in MEM until dmem_ready.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        dmem_ready,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_load,
    output logic        PCSel,
    output logic [2:0]  ImmSel,
    output logic        Asel,
    output logic        Bsel,
    output logic [3:0]  ALUSel,
    output logic        BrUn,
    output logic        mem_req,
    output logic        MemRW,
    output logic [1:0]  WBSel,
    output logic        RegWEn,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        taken_q, taken_d;
    logic [31:0] instret_q, instret_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    instr_cls_e  cls;
    logic        legal;
    logic        br_cond;
    logic        is_mem_op;
    logic        unused_ir_bits;

    // Instruction fields; register indices are consumed by the datapath, not here
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign cls       = classify(opcode);
    assign legal     = is_legal(cls, funct3, funct7);
    assign is_mem_op = (cls == CLS_LOAD) || (cls == CLS_STORE);
    assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

    assign state   = state_q;
    assign instret = instret_q;

    alu_decode u_alu_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_sel (ALUSel)
    );

    // State register; reset abandons any in-flight instruction immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (instr_valid) state_d = ST_DECODE;
            ST_DECODE:    state_d = legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE:   state_d = is_mem_op ? ST_MEM : ST_WRITEBACK;
            ST_MEM:       if (dmem_ready) state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
    end

    // Branch condition from the comparator; BrUn picks the unsigned compare
    // for bltu/bgeu so br_lt already carries the right sense
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = ~br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = ~br_lt;
            3'b110:  br_cond = br_lt;
            3'b111:  br_cond = ~br_lt;
            default: br_cond = 1'b0;
        endcase
    end

    // Next values for IR, the registered branch decision and the retire counter
    always_comb begin
        ir_d      = ir_q;
        taken_d   = taken_q;
        instret_d = instret_q;
        if ((state_q == ST_FETCH) && instr_valid) begin
            ir_d = instr;
        end
        if (state_q == ST_EXECUTE) begin
            taken_d = br_cond;
        end
        if (state_q == ST_WRITEBACK) begin
            instret_d = instret_q + 32'd1;  // wraps naturally at 2^32
        end
    end

    // IR, taken flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= 32'd0;
            taken_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    // Datapath selects decoded from IR; stable for the whole instruction
    always_comb begin
        ImmSel = IMM_I;
        Asel   = 1'b0;
        Bsel   = 1'b1;
        WBSel  = WB_ALU;
        BrUn   = 1'b0;
        case (cls)
            CLS_R:       Bsel = 1'b0;
            CLS_IALU:    ImmSel = IMM_I;
            CLS_LOAD:    WBSel = WB_MEM;
            CLS_STORE:   ImmSel = IMM_S;
            CLS_BRANCH: begin
                ImmSel = IMM_B;
                Asel   = 1'b1;
                BrUn   = (funct3[2:1] == 2'b11);
            end
            CLS_JAL: begin
                ImmSel = IMM_J;
                Asel   = 1'b1;
                WBSel  = WB_PC4;
            end
            CLS_JALR:    WBSel = WB_PC4;
            CLS_LUI: begin
                ImmSel = IMM_U;
                WBSel  = WB_IMM;
            end
            CLS_AUIPC: begin
                ImmSel = IMM_U;
                Asel   = 1'b1;
            end
            default:     Bsel = 1'b0;
        endcase
    end

    // Per-state strobes; each one is confined to a single state
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        PCSel    = 1'b0;
        mem_req  = 1'b0;
        MemRW    = 1'b0;
        RegWEn   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                // Gated so a valid word presented during reset cannot load
                ir_load  = instr_valid & rst_n;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                MemRW   = (cls == CLS_STORE);
            end
            ST_WRITEBACK: begin
                pc_load = 1'b1;
                PCSel   = (cls == CLS_JAL) || (cls == CLS_JALR) ||
                          ((cls == CLS_BRANCH) && taken_q);
                RegWEn  = (cls != CLS_STORE) && (cls != CLS_BRANCH);
            end
            ST_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl against a per-instruction reference model.
// Latency: driver follows the expected cycle budget of each instruction.
// Backpressure: imem and dmem wait cycles are randomized by the driver.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        dmem_ready;
    logic        br_eq;
    logic        br_lt;
    logic        imem_req;
    logic        ir_load;
    logic        pc_load;
    logic        PCSel;
    logic [2:0]  ImmSel;
    logic        Asel;
    logic        Bsel;
    logic [3:0]  ALUSel;
    logic        BrUn;
    logic        mem_req;
    logic        MemRW;
    logic [1:0]  WBSel;
    logic        RegWEn;
    logic        trap;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .dmem_ready  (dmem_ready),
        .br_eq       (br_eq),
        .br_lt       (br_lt),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_load     (pc_load),
        .PCSel       (PCSel),
        .ImmSel      (ImmSel),
        .Asel        (Asel),
        .Bsel        (Bsel),
        .ALUSel      (ALUSel),
        .BrUn        (BrUn),
        .mem_req     (mem_req),
        .MemRW       (MemRW),
        .WBSel       (WBSel),
        .RegWEn      (RegWEn),
        .trap        (trap),
        .state       (state),
        .instret     (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          trap;
        bit          is_mem;
        logic [3:0]  alu;
        logic        asel;
        logic        bsel;
        logic [2:0]  imm;
        logic [1:0]  wb;
        logic        brun;
        logic        pcsel;
        logic        regwen;
        logic        memrw;
        int          lat;
        int          memcyc;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what one instruction should look like on the outputs
    function automatic exp_t model(input logic [31:0] ins, input logic eq, input logic lt,
                                   input int mw, input logic [31:0] icount);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] base [8];
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        // funct3 order: add sll slt sltu xor srl or and
        base = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
        e.trap = 0; e.is_mem = 0; e.alu = 4'd1; e.asel = 0; e.bsel = 1;
        e.imm = 3'd0; e.wb = 2'd1; e.brun = 0; e.pcsel = 0; e.regwen = 1; e.memrw = 0;
        case (op)
            7'b0110011: begin
                e.bsel = 0;
                if (f7 != 7'h00 && f7 != 7'h20) e.trap = 1;
                if (f3 == 3'd0 && f7[5])      e.alu = 4'd2;
                else if (f3 == 3'd5 && f7[5]) e.alu = 4'd8;
                else                          e.alu = base[f3];
            end
            7'b0010011: e.alu = (f3 == 3'd5 && f7[5]) ? 4'd8 : base[f3];
            7'b0000011: begin e.is_mem = 1; e.wb = 2'd0; end
            7'b0100011: begin e.is_mem = 1; e.imm = 3'd1; e.memrw = 1; e.regwen = 0; end
            7'b1100011: begin
                e.imm = 3'd2; e.asel = 1; e.regwen = 0;
                e.brun = (f3 == 3'd6 || f3 == 3'd7);
                if (f3 == 3'd2 || f3 == 3'd3) e.trap = 1;
                case (f3)
                    3'd0:       e.pcsel = eq;
                    3'd1:       e.pcsel = !eq;
                    3'd4, 3'd6: e.pcsel = lt;
                    default:    e.pcsel = !lt;
                endcase
            end
            7'b1101111: begin e.imm = 3'd4; e.asel = 1; e.wb = 2'd2; e.pcsel = 1; end
            7'b1100111: begin e.wb = 2'd2; e.pcsel = 1; end
            7'b0110111: begin e.imm = 3'd3; e.alu = 4'd0; e.wb = 2'd3; end
            7'b0010111: begin e.imm = 3'd3; e.asel = 1; end
            default:    e.trap = 1;
        endcase
        e.memcyc  = e.is_mem ? mw + 1 : 0;
        e.lat     = 3 + e.memcyc;
        e.instret = icount;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        r = $urandom;
        k = $urandom_range(0, 19);
        if (k < 18) r[6:0] = ops[k % 9];
        if (r[6:0] == 7'b0110011 && $urandom_range(0, 9) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic noise();
        instr_valid = 1'($urandom_range(0, 1));
        dmem_ready  = 1'($urandom_range(0, 1));
        instr       = $urandom;
    endtask

    // Drive one instruction; caller starts and ends at posedge+1 in FETCH
    task automatic issue(input logic [31:0] ins, input logic eq, input logic lt,
                         input int fw, input int mw);
        exp_t e;
        e = model(ins, eq, lt, mw, exp_instret);
        if (!e.trap) begin
            sb_q.push_back(e);
            exp_instret = exp_instret + 32'd1;
        end
        for (int i = 0; i < fw; i++) begin
            instr = $urandom; instr_valid = 1'b0;
            @(posedge clk); #1;
            check("fetch_wait_state", 32'(state), 32'd0);
        end
        instr = ins; instr_valid = 1'b1; br_eq = eq; br_lt = lt;
        dmem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check("decode_state", 32'(state), 32'd1);
        noise();
        @(posedge clk); #1;
        if (e.trap) begin
            for (int i = 0; i < 10; i++) begin
                check("trap_state", 32'(state), 32'd5);
                check("trap_flag", 32'(trap), 32'd1);
                check("trap_strobes", 32'({imem_req, ir_load, pc_load, mem_req, MemRW, RegWEn}), 32'd0);
                noise();
                @(posedge clk); #1;
            end
            instr_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check("trap_reset_state", 32'(state), 32'd0);
            check("trap_reset_flag", 32'(trap), 32'd0);
            check("trap_reset_instret", instret, 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            exp_instret = 32'd0;
            return;
        end
        check("execute_state", 32'(state), 32'd2);
        noise();
        @(posedge clk); #1;
        if (e.is_mem) begin
            for (int w = 0; w <= mw; w++) begin
                check("mem_state", 32'(state), 32'd3);
                instr_valid = 1'($urandom_range(0, 1));
                dmem_ready  = (w == mw);
                @(posedge clk); #1;
            end
        end
        check("writeback_state", 32'(state), 32'd4);
        noise();
        @(posedge clk); #1;
        check("refetch_state", 32'(state), 32'd0);
        instr_valid = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    // Monitor: on every retirement pop the oldest expectation and compare
    initial begin
        int   cyc;
        int   mem_cycles;
        logic memrw_seen;
        exp_t e;
        cyc = 0; mem_cycles = 0; memrw_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; mem_cycles = 0; memrw_seen = 1'b0;
            end else begin
                if (ir_load) begin
                    cyc = 0; mem_cycles = 0; memrw_seen = 1'b0;
                end else begin
                    cyc++;
                end
                if (mem_req) begin
                    mem_cycles++;
                    if (MemRW) memrw_seen = 1'b1;
                end
                if (pc_load) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_retire: pc_load=1 with no instruction outstanding at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("ALUSel", 32'(ALUSel), 32'(e.alu));
                        check("Asel", 32'(Asel), 32'(e.asel));
                        check("Bsel", 32'(Bsel), 32'(e.bsel));
                        check("ImmSel", 32'(ImmSel), 32'(e.imm));
                        check("WBSel", 32'(WBSel), 32'(e.wb));
                        check("BrUn", 32'(BrUn), 32'(e.brun));
                        check("PCSel", 32'(PCSel), 32'(e.pcsel));
                        check("RegWEn", 32'(RegWEn), 32'(e.regwen));
                        check("instret_at_wb", instret, e.instret);
                        check("latency", 32'(cyc), 32'(e.lat));
                        check("mem_cycles", 32'(mem_cycles), 32'(e.memcyc));
                        check("MemRW", 32'(memrw_seen), 32'(e.memrw));
                        check("wb_other_strobes", 32'({imem_req, ir_load, mem_req, MemRW}), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; instr = 32'd0; instr_valid = 1'b0;
        dmem_ready = 1'b0; br_eq = 1'b0; br_lt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_strobes", 32'({ir_load, pc_load, mem_req, MemRW, RegWEn, PCSel}), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_alusel", 32'(ALUSel), 32'd0);
        rst_n = 1'b1;

        // Reset while a load waits in MEM: abort with no retirement side effects
        instr = 32'h0040A283; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_in_mem", 32'(state), 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_pc_load", 32'(pc_load), 32'd0);
        check("abort_regwen", 32'(RegWEn), 32'd0);
        check("abort_instret", instret, 32'd0);
        check("abort_imem_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        check("abort_regwen_held", 32'(RegWEn), 32'd0);
        rst_n = 1'b1;

        // Directed instructions
        issue(32'h002081B3, 1'b0, 1'b0, 0, 0);  // add x3,x1,x2
        issue(32'h402081B3, 1'b0, 1'b0, 1, 0);  // sub
        issue(32'h4020D193, 1'b0, 1'b0, 0, 0);  // srai x3,x1,2
        issue(32'h0040A283, 1'b0, 1'b0, 2, 3);  // lw, dmem 3 cycles late
        issue(32'h0020A223, 1'b0, 1'b0, 0, 1);  // sw
        issue(32'h00208463, 1'b1, 1'b0, 0, 0);  // beq taken
        issue(32'h00208463, 1'b0, 1'b0, 0, 0);  // beq not taken
        issue(32'h0020E463, 1'b0, 1'b1, 0, 0);  // bltu taken
        issue(32'h008000EF, 1'b0, 1'b0, 0, 0);  // jal
        issue(32'h000080E7, 1'b0, 1'b0, 0, 0);  // jalr
        issue(32'h123452B7, 1'b0, 1'b0, 0, 0);  // lui
        issue(32'h00001297, 1'b0, 1'b0, 0, 0);  // auipc
        issue(32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);  // illegal -> trap

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            issue(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 4));
        end

        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("final_instret", instret, exp_instret);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
